// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 Game-of-Life tile: quadrant selectors and
// the row/column to quadrant-word bit mapping.
package life_pkg;

    localparam logic [1:0] Q_TL = 2'b00;
    localparam logic [1:0] Q_BL = 2'b01;
    localparam logic [1:0] Q_TR = 2'b10;
    localparam logic [1:0] Q_BR = 2'b11;

    // Column-major position inside a 4x4 quadrant word.
    function automatic logic [3:0] idx(input int r, input int c);
        return 4'(4 * c + r);
    endfunction

endpackage

// File: rtl/life_cell.sv
// One Game-of-Life cell holding current and previous generation (B3/S23).
// Latency: next generation visible the clock after adv; load visible next clock.
// Backpressure: none; load overrides adv in the same clock.
module life_cell
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] nbr,
    input  logic       adv,
    input  logic       load,
    input  logic       load_val,
    output logic       cur,
    output logic       prev
);

    logic [3:0] count;
    logic       next_val;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(nbr[i]);
        end
        next_val = (count == 4'd3) || (cur && count == 4'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else if (load) begin
            cur  <= load_val;
            prev <= load_val;
        end else if (adv) begin
            prev <= cur;
            cur  <= next_val;
        end
    end

endmodule

// File: rtl/life_array_8x8.sv
// 8x8 Game-of-Life tile with edge/corner neighbour inputs and quadrant host access.
// Latency: one generation per rising edge of step, visible the next clock; reads are combinational.
// Backpressure: none; a write in the same clock as a step edge drops that generation.
module life_array_8x8
    import life_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] vali,
    input  logic [1:0]  vali_selector,
    input  logic        write_enb,
    input  logic [1:0]  valo_selector,
    output logic [15:0] valo,
    output logic [15:0] valo_prev,
    input  logic [7:0]  n,
    input  logic [7:0]  s,
    input  logic [7:0]  w,
    input  logic [7:0]  e,
    input  logic        nw,
    input  logic        ne,
    input  logic        se,
    input  logic        sw,
    input  logic        step
);

    logic              step_q;
    logic              adv;
    logic [63:0]       cur_v;
    logic [63:0]       prev_v;
    logic [9:0][9:0]   pad;
    logic [3:0][15:0]  cur_q;
    logic [3:0][15:0]  prev_q;

    assign adv = step & ~step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // 10x10 padded grid: ring of boundary inputs around the live cells.
    assign pad[0][0] = nw;
    assign pad[0][9] = ne;
    assign pad[9][0] = sw;
    assign pad[9][9] = se;

    for (genvar i = 0; i < 8; i++) begin : g_edge
        assign pad[0][i+1] = n[i];
        assign pad[9][i+1] = s[i];
        assign pad[i+1][0] = w[i];
        assign pad[i+1][9] = e[i];
    end

    for (genvar r = 0; r < 8; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            localparam logic [1:0] Q = {c >= 4, r >= 4};
            localparam logic [3:0] B = idx(r % 4, c % 4);

            life_cell u_cell (
                .clk      (clk),
                .reset    (reset),
                .nbr      ({pad[r][c],   pad[r][c+1],   pad[r][c+2],
                            pad[r+1][c],                pad[r+1][c+2],
                            pad[r+2][c], pad[r+2][c+1], pad[r+2][c+2]}),
                .adv      (adv),
                .load     (write_enb && (vali_selector == Q)),
                .load_val (vali[B]),
                .cur      (cur_v[r*8+c]),
                .prev     (prev_v[r*8+c])
            );

            assign pad[r+1][c+1] = cur_v[r*8+c];
            assign cur_q[Q][B]   = cur_v[r*8+c];
            assign prev_q[Q][B]  = prev_v[r*8+c];
        end
    end

    assign valo      = cur_q[valo_selector];
    assign valo_prev = prev_q[valo_selector];

endmodule

// File: tb/tb_life_array_8x8.sv
// Directed checks of the 8x8 Game-of-Life tile against hand-derived patterns.
module tb_life_array_8x8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] vali = '0;
    logic [1:0]  vali_selector = '0;
    logic        write_enb = 1'b0;
    logic [1:0]  valo_selector = '0;
    logic [15:0] valo;
    logic [15:0] valo_prev;
    logic [7:0]  n = '0, s = '0, w = '0, e = '0;
    logic        nw = 1'b0, ne = 1'b0, se = 1'b0, sw = 1'b0;
    logic        step = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    life_array_8x8 dut (
        .clk           (clk),
        .reset         (reset),
        .vali          (vali),
        .vali_selector (vali_selector),
        .write_enb     (write_enb),
        .valo_selector (valo_selector),
        .valo          (valo),
        .valo_prev     (valo_prev),
        .n             (n),
        .s             (s),
        .w             (w),
        .e             (e),
        .nw            (nw),
        .ne            (ne),
        .se            (se),
        .sw            (sw),
        .step          (step)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step = 1'b0;
        write_enb = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic write_q(input logic [1:0] sel, input logic [15:0] val);
        vali_selector = sel;
        vali = val;
        write_enb = 1'b1;
        tick();
        write_enb = 1'b0;
    endtask

    task automatic step_edge();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int q = 0; q < 4; q++) begin
            valo_selector = 2'(q);
            #1;
            tests++;
            if (valo !== 16'h0000) begin
                fails++;
                $display("FAIL reset_valo q=%0d got %h want 0000", q, valo);
            end
            tests++;
            if (valo_prev !== 16'h0000) begin
                fails++;
                $display("FAIL reset_prev q=%0d got %h want 0000", q, valo_prev);
            end
        end
    endtask

    task automatic test_single_cell();
        write_q(2'b00, 16'h0001);
        valo_selector = 2'b00;
        #1;
        tests++;
        if (valo !== 16'h0001) begin
            fails++;
            $display("FAIL single_write got %h want 0001", valo);
        end
        step_edge();
        tests++;
        if (valo !== 16'h0000) begin
            fails++;
            $display("FAIL single_dies got %h want 0000", valo);
        end
    endtask

    task automatic test_block();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h8000; exp_q[1] = 16'h1000;
        exp_q[2] = 16'h0008; exp_q[3] = 16'h0001;
        for (int q = 0; q < 4; q++) write_q(2'(q), exp_q[q]);
        step_edge();
        for (int q = 0; q < 4; q++) begin
            valo_selector = 2'(q);
            #1;
            tests++;
            if (valo !== exp_q[q]) begin
                fails++;
                $display("FAIL block_still q=%0d got %h want %h", q, valo, exp_q[q]);
            end
        end
    endtask

    task automatic test_prev_history();
        do_reset();
        write_q(2'b00, 16'h0025);
        valo_selector = 2'b00;
        #1;
        tests++;
        if (valo_prev !== 16'h0025) begin
            fails++;
            $display("FAIL hist_write_prev got %h want 0025", valo_prev);
        end
        step_edge();
        tests++;
        if (valo_prev !== 16'h0025) begin
            fails++;
            $display("FAIL hist_gen1_prev got %h want 0025", valo_prev);
        end
        tests++;
        if (valo !== 16'h0022) begin
            fails++;
            $display("FAIL hist_gen1_cur got %h want 0022", valo);
        end
        step_edge();
        tests++;
        if (valo_prev !== 16'h0022) begin
            fails++;
            $display("FAIL hist_gen2_prev got %h want 0022", valo_prev);
        end
        step_edge();
        tests++;
        if (valo_prev !== 16'h0000) begin
            fails++;
            $display("FAIL hist_gen3_prev got %h want 0000", valo_prev);
        end
    endtask

    task automatic test_edges(input string name, input logic corner, input logic [7:0] edge_v,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_q [4];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        do_reset();
        {nw, ne, se, sw} = {4{corner}};
        {n, s, w, e} = {4{edge_v}};
        step = 1'b1;
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int q = 0; q < 4; q++) begin
                valo_selector = 2'(q);
                #1;
                tests++;
                if (valo !== exp_q[q]) begin
                    fails++;
                    $display("FAIL %s pass=%0d q=%0d got %h want %h", name, pass, q, valo, exp_q[q]);
                end
            end
            tick();
            tick();
        end
        step = 1'b0;
        {nw, ne, se, sw} = 4'b0;
        {n, s, w, e} = '0;
    endtask

    task automatic test_write_priority();
        do_reset();
        step = 1'b1;
        write_q(2'b00, 16'h0001);
        valo_selector = 2'b00;
        #1;
        tests++;
        if (valo !== 16'h0001) begin
            fails++;
            $display("FAIL wr_prio_cur got %h want 0001", valo);
        end
        tests++;
        if (valo_prev !== 16'h0001) begin
            fails++;
            $display("FAIL wr_prio_prev got %h want 0001", valo_prev);
        end
        step = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (valo !== 16'h0000) begin
            fails++;
            $display("FAIL midrun_reset_cur got %h want 0000", valo);
        end
        tests++;
        if (valo_prev !== 16'h0000) begin
            fails++;
            $display("FAIL midrun_reset_prev got %h want 0000", valo_prev);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_block();
        test_prev_history();
        test_edges("edges_81", 1'b1, 8'h81, 16'h0001, 16'h0008, 16'h1000, 16'h8000);
        test_edges("edges_3c", 1'b0, 8'h3C, 16'h1008, 16'h8001, 16'h8001, 16'h1008);
        test_write_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
